// File: rtl/y86_dmem_arbiter_pkg.sv
// Shared definitions for the Y86 data-memory arbiter: status codes, FSM states,
// owner encoding and the default memory depth.
package y86_mem_pkg;

    localparam logic [2:0] STAT_AOK = 3'b000;
    localparam logic [2:0] STAT_INS = 3'b001;
    localparam logic [2:0] STAT_ADR = 3'b010;
    localparam logic [2:0] STAT_HLT = 3'b100;

    localparam int DEF_MEM_WORDS = 4096;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_P = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/y86_dmem_arbiter_starve_ctr.sv
// Saturating counter of consecutive pipeline grants made while the debug port
// waits; sat tells the arbiter to hand the next slot to the debug port.
module y86_starve_ctr #(
    parameter int MAX_STARVE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CW = $clog2(MAX_STARVE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_STARVE);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat = (cnt_q == CNT_MAX);

endmodule

// File: rtl/y86_dmem_arbiter.sv
// Shares the single-port data memory between the pipeline memory stage (P) and
// the debug/loader port (D); every access takes IDLE -> ACCESS -> RESP.
module y86_dmem_arbiter
    import y86_mem_pkg::*;
#(
    parameter int MEM_WORDS  = DEF_MEM_WORDS,
    parameter int AW         = $clog2(MEM_WORDS),
    parameter int MAX_STARVE = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p_req,
    input  logic          p_we,
    input  logic [63:0]   p_addr,
    input  logic [63:0]   p_wdata,
    output logic          p_done,
    output logic [63:0]   p_rdata,
    output logic [2:0]    p_stat,
    output logic          p_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [63:0]   d_addr,
    input  logic [63:0]   d_wdata,
    output logic          d_done,
    output logic [63:0]   d_rdata,
    output logic [2:0]    d_stat,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [63:0]   mem_wdata,
    input  logic [63:0]   mem_rdata
);

    localparam logic [63:0] ADDR_LIMIT = 64'(MEM_WORDS);

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [63:0]   wdata_q, wdata_d;

    logic arb, grant_p, grant_d, starve_sat;

    // D only displaces a concurrent P request once P has had its run of grants.
    assign arb     = (state_q == IDLE) && (p_req || d_req);
    assign grant_d = arb && d_req && (!p_req || starve_sat);
    assign grant_p = arb && !grant_d;

    y86_starve_ctr #(.MAX_STARVE(MAX_STARVE)) u_starve (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (grant_p && d_req),
        .clr   (grant_d || ((state_q == IDLE) && !d_req)),
        .sat   (starve_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= OWN_P;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // The range check is folded into err at latch time, so only AW address bits are kept.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = ACCESS;
                    owner_d = OWN_D;
                    we_d    = d_we;
                    err_d   = (d_addr >= ADDR_LIMIT);
                    addr_d  = d_addr[AW-1:0];
                    wdata_d = d_wdata;
                end else if (grant_p) begin
                    state_d = ACCESS;
                    owner_d = OWN_P;
                    we_d    = p_we;
                    err_d   = (p_addr >= ADDR_LIMIT);
                    addr_d  = p_addr[AW-1:0];
                    wdata_d = p_wdata;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        p_done    = 1'b0;
        p_rdata   = '0;
        p_stat    = STAT_AOK;
        d_done    = 1'b0;
        d_rdata   = '0;
        d_stat    = STAT_AOK;
        case (state_q)
            ACCESS: begin
                if (!err_q) begin
                    mem_en    = 1'b1;
                    mem_we    = we_q;
                    mem_addr  = addr_q;
                    mem_wdata = wdata_q;
                end
            end
            RESP: begin
                if (owner_q == OWN_P) begin
                    p_done  = 1'b1;
                    p_stat  = err_q ? STAT_ADR : STAT_AOK;
                    p_rdata = (!err_q && !we_q) ? mem_rdata : 64'd0;
                end else begin
                    d_done  = 1'b1;
                    d_stat  = err_q ? STAT_ADR : STAT_AOK;
                    d_rdata = (!err_q && !we_q) ? mem_rdata : 64'd0;
                end
            end
            default: ;
        endcase
    end

    assign p_stall = p_req && !p_done;

endmodule

// File: doc/y86_dmem_arbiter.md
Name: y86_dmem_arbiter

Overview:
- Sequences all accesses to the single-port pipelined data memory (MEM_WORDS x 64-bit words, 1-cycle synchronous read) and shares it between two requesters.
- Requester P is the pipeline memory stage. Requester D is the debug/program-loader port.
- Performs an unsigned range check on every address before issuing it, and returns a Y86 status code with each completion.
- Stalls the memory stage whenever P's request is not yet complete.

Parameters:
MEM_WORDS, 4096, number of 64-bit data memory words; valid addresses are 0 .. MEM_WORDS-1
AW, 12, memory array address width, equal to clog2(MEM_WORDS)
MAX_STARVE, 4, consecutive P grants while D is waiting, after which D wins the next arbitration

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
p_req  in  1  P request; held high until p_done
p_we  in  1  P write (1) / read (0); stable while p_req is high
p_addr  in  64  P word address, unsigned (valE or valA from the memory stage)
p_wdata  in  64  P write data
p_done  out  1  one-cycle completion pulse for P
p_rdata  out  64  P read data, valid while p_done is high
p_stat  out  3  P completion status, valid while p_done is high
p_stall  out  1  stalls the memory stage
d_req  in  1  D request; same rules as p_req
d_we  in  1  D write/read
d_addr  in  64  D word address
d_wdata  in  64  D write data
d_done  out  1  one-cycle completion pulse for D
d_rdata  out  64  D read data
d_stat  out  3  D completion status
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  AW  memory word address
mem_wdata  out  64  memory write data
mem_rdata  in  64  memory read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: all outputs 0 except p_stall. p_stall is combinational and equals p_req & ~p_done, so it follows p_req during reset. Internally: FSM in IDLE, starve counter 0, owner = P.
- Status codes: AOK=3'b000, INS=3'b001, ADR=3'b010, HLT=3'b100. This block emits only AOK or ADR.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No requests: stay in IDLE.
  - Any request: latch the winner's we/addr/wdata and owner, then go to ACCESS.
  - Winner selection: P wins, unless both request and starve_cnt == MAX_STARVE, in which case D wins.
- Starve counter: +1 on each P grant while d_req is high; cleared on every D grant and whenever d_req is low at arbitration; saturates at MAX_STARVE.
- ACCESS:
  - Address in range (latched addr < MEM_WORDS, unsigned compare on the full 64 bits): drive mem_en=1, mem_we=latched we, mem_addr=addr[AW-1:0], mem_wdata=latched wdata.
  - Address out of range: mem_en stays 0 and the error flag is set.
  - Always go to RESP next.
- RESP:
  - Pulse the owner's *_done for exactly one cycle.
  - *_stat = ADR if the error flag is set, else AOK.
  - *_rdata = mem_rdata for an in-range read, else 64'd0.
  - The non-owner's done/rdata/stat stay 0.
  - Always return to IDLE.
- Latency and throughput: exactly 3 cycles from request sampled in IDLE to done. Back-to-back throughput is one access per 3 cycles.
- Request rules:
  - A requester deasserts req in the cycle after its done, or keeps it high to issue a new access.
  - A req sampled in IDLE in the cycle after its done is treated as a new request.
  - Requests are not sampled in ACCESS or RESP. A req that drops before its done cancels nothing: the latched access completes and done still pulses.
- Write semantics: the write commits in ACCESS. A read of the same address issued afterwards returns the new data.
- Reset mid-operation: rst_n low in ACCESS forces mem_en low immediately; no done is produced for the cut access. Any write already committed remains in memory; the requester re-issues.
- p_stall is high while p_req is high and p_done is low, including while D owns the memory.

Decomposition:
- Package y86_mem_pkg holds: stat codes (STAT_AOK, STAT_INS, STAT_ADR, STAT_HLT), the default MEM_WORDS, the FSM state type (IDLE/ACCESS/RESP), and the owner encoding (OWN_P, OWN_D).
- One sub-module, y86_starve_ctr: a saturating counter with inc/clr inputs and a sat output, parameterised by MAX_STARVE.

Test Plan:
- P read alone: p_req=1, p_we=0, p_addr=64'd16, memory word 16 = 64'd17 -> p_done at cycle 3 with p_rdata=17, p_stat=3'b000; p_stall high for cycles 1-2.
- P write then read: write 64'hDEAD to addr 100, then read addr 100 -> p_rdata=64'hDEAD, both with stat AOK.
- Out of range: p_addr=64'd4096 (and 64'hFFFF_FFFF_FFFF_FFF8) -> mem_en never asserts; p_done with p_stat=3'b010, p_rdata=0.
- Contention: p_req and d_req both held continuously with MAX_STARVE=4 -> grant order P,P,P,P,D,P,P,P,P,D; d_done appears every 5th completion.
- Reset mid-access: rst_n low during ACCESS of a D write -> mem_en drops the same cycle, no d_done; after release, FSM is in IDLE and a P read completes in 3 cycles.
- Early drop: d_req pulsed for 1 cycle in IDLE -> access still completes and d_done pulses once; no second access is issued.
